// File: rtl/rv_pkg.sv
// rv_pkg: shared constants, register-address type and address validity helper
// for the integer register file and its scoreboard.
//   XLEN_DEF / NREG_DEF : default register width and register count
//   AW                  : register address width (RISC-V 5-bit encodings)
//   regaddr_t           : register address type
//   is_valid_reg()      : 1 when addr names a writable register (non-zero, < nreg)
package rv_pkg;
   localparam int XLEN_DEF = 64;
   localparam int NREG_DEF = 32;
   localparam int AW       = 5;
   typedef logic [AW-1:0] regaddr_t;
   function automatic logic is_valid_reg(input regaddr_t addr, input int nreg);
      return (addr != '0) && (int'(addr) < nreg);
   endfunction
endpackage

// File: rtl/rv_scoreboard.sv
// rv_scoreboard: per-register busy bits with rst > flush > rsv > wr priority
// and a registered population count of the busy vector.
//   clk, rst           : clock, synchronous active-high reset
//   rsv_en, rsv_addr   : reserve a destination (sets its busy bit)
//   wr_en, wr_addr     : writeback (clears its busy bit unless re-reserved)
//   flush              : clear every busy bit
//   busy               : busy bit per register X1..X(NREG-1)
//   busy_cnt           : number of busy registers, registered with busy
module rv_scoreboard
   import rv_pkg::*;
#(
   parameter int NREG = NREG_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       rsv_en,
   input  regaddr_t                   rsv_addr,
   input  logic                       wr_en,
   input  regaddr_t                   wr_addr,
   input  logic                       flush,
   output logic [NREG-1:1]            busy,
   output logic [$clog2(NREG+1)-1:0]  busy_cnt
);
   localparam int CW = $clog2(NREG + 1);
   logic [NREG-1:1] busy_nxt;
   logic [CW-1:0]   cnt_nxt;
   // Out-of-range addresses never match a loop index, so they fall through
   // untouched; rsv is applied after wr so a new producer wins the tie.
   always_comb begin
      busy_nxt = busy;
      cnt_nxt  = '0;
      for (int i = 1; i < NREG; i++) begin
         if (wr_en && wr_addr == regaddr_t'(i)) busy_nxt[i] = 1'b0;
         if (rsv_en && rsv_addr == regaddr_t'(i)) busy_nxt[i] = 1'b1;
         if (flush) busy_nxt[i] = 1'b0;
         cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
      end
   end
   always_ff @(posedge clk) begin
      busy     <= rst ? '0 : busy_nxt;
      busy_cnt <= rst ? '0 : cnt_nxt;
   end
endmodule

// File: rtl/rv_regfile_sb.sv
// rv_regfile_sb: multi-read-port integer register file with write-through
// bypass and per-register busy scoreboard; x0 is hard-wired to zero.
//   clk, rst          : clock, synchronous active-high reset
//   rd_addr[p]        : read address per port
//   rd_data[p]        : combinational read data per port
//   rd_busy[p]        : combinational pending-producer flag per port
//   wr_en/addr/data   : writeback, also releases the reservation
//   rsv_en, rsv_addr  : issue-time destination reservation
//   flush             : clear all busy bits, data untouched
//   busy_cnt          : registered count of busy registers
module rv_regfile_sb
   import rv_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int NREG   = NREG_DEF,
   parameter int NRP    = 2,
   parameter int BYPASS = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NRP-1:0][AW-1:0]     rd_addr,
   output logic [NRP-1:0][XLEN-1:0]   rd_data,
   output logic [NRP-1:0]             rd_busy,
   input  logic                       wr_en,
   input  logic [AW-1:0]              wr_addr,
   input  logic [XLEN-1:0]            wr_data,
   input  logic                       rsv_en,
   input  logic [AW-1:0]              rsv_addr,
   input  logic                       flush,
   output logic [$clog2(NREG+1)-1:0]  busy_cnt
);
   logic [XLEN-1:0] regs [1:NREG-1];
   logic [NREG-1:1] busy;
   logic            wr_ok;
   assign wr_ok = wr_en && is_valid_reg(wr_addr, NREG);
   always_ff @(posedge clk) begin
      for (int i = 1; i < NREG; i++)
         if (rst) regs[i] <= '0;
         else if (wr_ok && wr_addr == regaddr_t'(i)) regs[i] <= wr_data;
   end
   rv_scoreboard #(.NREG(NREG)) u_sb (
      .clk      (clk),
      .rst      (rst),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .flush    (flush),
      .busy     (busy),
      .busy_cnt (busy_cnt)
   );
   for (genvar p = 0; p < NRP; p++) begin : g_rd
      logic [XLEN-1:0] arr;
      logic            arr_busy;
      logic            hit;
      // x0 and out-of-range addresses match no entry and read as 0 / not busy.
      always_comb begin
         arr      = '0;
         arr_busy = 1'b0;
         for (int i = 1; i < NREG; i++)
            if (rd_addr[p] == regaddr_t'(i)) begin
               arr      = regs[i];
               arr_busy = busy[i];
            end
      end
      // A forwarded value is available now, so the port is never busy on a hit.
      assign hit        = (BYPASS != 0) && wr_ok && (wr_addr == rd_addr[p]);
      assign rd_data[p] = hit ? wr_data : arr;
      assign rd_busy[p] = !hit && arr_busy;
   end
endmodule

// File: tb/tb_rv_regfile_sb.sv
// tb_rv_regfile_sb: self-checking bench for rv_regfile_sb (bypass, no-bypass, RV32E variants).
module tb_rv_regfile_sb;
   localparam logic [63:0] D = 64'hDEAD_BEEF_0123_4567;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic            rst, wr_en, rsv_en, flush;
   logic [4:0]      wr_addr, rsv_addr;
   logic [63:0]     wr_data;
   logic [1:0][4:0] rd_addr;
   logic [1:0][63:0] a_d, b_d;
   logic [1:0]      a_b, b_b;
   logic [5:0]      a_cnt, b_cnt;
   logic            c_wr_en, c_rsv_en, c_flush;
   logic [4:0]      c_wr_addr, c_rsv_addr;
   logic [31:0]     c_wr_data;
   logic [2:0][4:0] c_ra;
   logic [2:0][31:0] c_d;
   logic [2:0]      c_b;
   logic [4:0]      c_cnt;
   int total = 0;
   int bad = 0;
   rv_regfile_sb #(.XLEN(64), .NREG(32), .NRP(2), .BYPASS(1)) u_a (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(a_d), .rd_busy(a_b),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
      .rsv_addr(rsv_addr), .flush(flush), .busy_cnt(a_cnt));
   rv_regfile_sb #(.XLEN(64), .NREG(32), .NRP(2), .BYPASS(0)) u_b (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(b_d), .rd_busy(b_b),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
      .rsv_addr(rsv_addr), .flush(flush), .busy_cnt(b_cnt));
   rv_regfile_sb #(.XLEN(32), .NREG(16), .NRP(3), .BYPASS(1)) u_c (
      .clk(clk), .rst(rst), .rd_addr(c_ra), .rd_data(c_d), .rd_busy(c_b),
      .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data), .rsv_en(c_rsv_en),
      .rsv_addr(c_rsv_addr), .flush(c_flush), .busy_cnt(c_cnt));
   typedef struct {
      logic rst; logic we; logic [4:0] wa; logic [63:0] wd; logic re; logic [4:0] ra; logic fl;
      logic [4:0] a0; logic [4:0] a1;
      logic [63:0] d0; logic [63:0] d1; logic b0; logic b1; logic [5:0] cnt;
      logic [63:0] nd1; logic nb1;
   } vec_t;
   typedef struct {
      logic we; logic [4:0] wa; logic [31:0] wd; logic re; logic [4:0] ra; logic fl;
      logic [2:0][4:0] a; logic [2:0][31:0] d; logic [2:0] b; logic [4:0] cnt;
   } cvec_t;
   vec_t  v [23];
   vec_t  q [$];
   cvec_t cq [$];
   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", n, act, exp);
      end
   endtask
   task automatic c_step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic re, input logic [4:0] ra, input logic fl,
                         input logic [2:0][4:0] a, input logic [2:0][31:0] d,
                         input logic [2:0] b, input logic [4:0] cnt, input int k);
      cvec_t e;
      @(negedge clk);
      c_wr_en = we; c_wr_addr = wa; c_wr_data = wd; c_rsv_en = re; c_rsv_addr = ra;
      c_flush = fl; c_ra = a;
      cq.push_back('{we, wa, wd, re, ra, fl, a, d, b, cnt});
      #2;
      e = cq.pop_front();
      for (int p = 0; p < 3; p++) begin
         chk($sformatf("c%0d d%0d", k, p), 64'(c_d[p]), 64'(e.d[p]));
         chk($sformatf("c%0d b%0d", k, p), 64'(c_b[p]), 64'(e.b[p]));
      end
      chk($sformatf("c%0d cnt", k), 64'(c_cnt), 64'(e.cnt));
   endtask
   initial begin
      vec_t e;
      v[0]  = '{0,0,0,0,0,0,0, 5,7, 0,0,0,0,0, 0,0};
      v[1]  = '{0,1,5,D,0,0,0, 5,5, D,D,0,0,0, 0,0};
      v[2]  = '{0,1,0,ONES,0,0,0, 5,0, D,0,0,0,0, 0,0};
      v[3]  = '{0,0,0,0,0,0,0, 0,5, 0,D,0,0,0, D,0};
      v[4]  = '{0,1,7,'h55,0,0,0, 7,7, 'h55,'h55,0,0,0, 0,0};
      v[5]  = '{0,0,0,0,1,3,0, 3,7, 0,'h55,0,0,0, 'h55,0};
      v[6]  = '{0,0,0,0,1,4,0, 3,4, 0,0,1,0,1, 0,0};
      v[7]  = '{0,1,3,'h33,0,0,0, 3,4, 'h33,0,0,1,2, 0,1};
      v[8]  = '{0,1,4,'h44,1,4,0, 3,4, 'h33,'h44,0,0,1, 0,1};
      v[9]  = '{0,0,0,0,0,0,0, 4,3, 'h44,'h33,1,0,1, 'h33,0};
      v[10] = '{0,0,0,0,1,1,0, 4,1, 'h44,0,1,0,1, 0,0};
      v[11] = '{0,0,0,0,1,2,0, 1,2, 0,0,1,0,2, 0,0};
      v[12] = '{0,0,0,0,1,3,0, 2,3, 0,'h33,1,0,3, 'h33,0};
      v[13] = '{0,0,0,0,1,4,0, 3,4, 'h33,'h44,1,1,4, 'h44,1};
      v[14] = '{0,0,0,0,1,5,0, 5,6, D,0,0,0,4, 0,0};
      v[15] = '{0,0,0,0,1,6,0, 5,6, D,0,1,0,5, 0,0};
      v[16] = '{0,1,2,'h22,1,9,1, 6,2, 0,'h22,1,0,6, 0,1};
      v[17] = '{0,0,0,0,0,0,0, 9,2, 0,'h22,0,0,0, 'h22,0};
      v[18] = '{0,0,0,0,1,2,0, 2,2, 'h22,'h22,0,0,0, 'h22,0};
      v[19] = '{1,1,3,'h99,0,0,0, 2,3, 'h22,'h99,1,0,1, 'h33,0};
      v[20] = '{0,0,0,0,0,0,0, 2,3, 0,0,0,0,0, 0,0};
      v[21] = '{0,1,31,'h1F,0,0,0, 31,31, 'h1F,'h1F,0,0,0, 0,0};
      v[22] = '{0,0,0,0,0,0,0, 31,0, 'h1F,0,0,0,0, 0,0};
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rsv_en = 1'b0; rsv_addr = '0;
      flush = 1'b0; rd_addr = '0;
      c_wr_en = 1'b0; c_wr_addr = '0; c_wr_data = '0; c_rsv_en = 1'b0; c_rsv_addr = '0;
      c_flush = 1'b0; c_ra = '0;
      @(negedge clk);
      for (int i = 0; i < 23; i++) begin
         @(negedge clk);
         rst = v[i].rst; wr_en = v[i].we; wr_addr = v[i].wa; wr_data = v[i].wd;
         rsv_en = v[i].re; rsv_addr = v[i].ra; flush = v[i].fl;
         rd_addr[0] = v[i].a0; rd_addr[1] = v[i].a1;
         q.push_back(v[i]);
         #2;
         e = q.pop_front();
         chk($sformatf("r%0d d0", i), a_d[0], e.d0);
         chk($sformatf("r%0d d1", i), a_d[1], e.d1);
         chk($sformatf("r%0d b0", i), 64'(a_b[0]), 64'(e.b0));
         chk($sformatf("r%0d b1", i), 64'(a_b[1]), 64'(e.b1));
         chk($sformatf("r%0d cnt", i), 64'(a_cnt), 64'(e.cnt));
         chk($sformatf("r%0d nobyp d1", i), b_d[1], e.nd1);
         chk($sformatf("r%0d nobyp b1", i), 64'(b_b[1]), 64'(e.nb1));
         chk($sformatf("r%0d nobyp cnt", i), 64'(b_cnt), 64'(e.cnt));
      end
      c_step(0, 0, 0, 0, 0, 0, {5'd0, 5'd1, 5'd15}, '0, 3'b000, 0, 0);
      c_step(1, 20, 32'hABCD, 1, 20, 0, {5'd20, 5'd20, 5'd20}, '0, 3'b000, 0, 1);
      c_step(0, 0, 0, 0, 0, 0, {5'd20, 5'd4, 5'd20}, '0, 3'b000, 0, 2);
      c_step(1, 15, 32'hCAFE_F00D, 1, 15, 0, {5'd15, 5'd15, 5'd15},
             {32'hCAFE_F00D, 32'hCAFE_F00D, 32'hCAFE_F00D}, 3'b000, 0, 3);
      c_step(0, 0, 0, 0, 0, 0, {5'd15, 5'd15, 5'd15},
             {32'hCAFE_F00D, 32'hCAFE_F00D, 32'hCAFE_F00D}, 3'b111, 1, 4);
      c_step(0, 0, 0, 1, 16, 0, {5'd0, 5'd15, 5'd16}, {32'h0, 32'hCAFE_F00D, 32'h0}, 3'b010, 1, 5);
      c_step(0, 0, 0, 0, 0, 0, {5'd0, 5'd15, 5'd16}, {32'h0, 32'hCAFE_F00D, 32'h0}, 3'b010, 1, 6);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rv_regfile_sb.md
# rv_regfile_sb

Parametrised multi-read-port integer register file with write-through bypass and a per-register busy scoreboard. It sits in the decode/writeback boundary of the core. Decode reads operands and reserves destination registers at issue. Writeback writes results and releases the reservation. Register width, register count (RV32I/RV64I/RV32E) and read-port count are parameters. x0 is hard-wired to zero.

## Interface
- XLEN, 64, register width in bits.
- NREG, 32, number of architectural registers; 16 for RV32E; legal range 2..32.
- NRP, 2, number of read ports.
- BYPASS, 1, 1 = same-cycle write is forwarded to matching reads; 0 = reads see array only.
- AW (localparam), 5, address width, fixed at 5 for RISC-V encodings.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- rd_addr  in  NRP×AW  read addresses, one per port.
- rd_data  out  NRP×XLEN  read data per port, combinational.
- rd_busy  out  NRP  1 = operand at that port has a pending producer; combinational.
- wr_en  in  1  writeback valid.
- wr_addr  in  AW  writeback destination.
- wr_data  in  XLEN  writeback value.
- rsv_en  in  1  issue reserves a destination.
- rsv_addr  in  AW  reserved destination.
- flush  in  1  clear all busy bits; data untouched.
- busy_cnt  out  $clog2(NREG+1)  number of registers currently busy; registered.

## Operation
- Storage: NREG-1 registers X1..X(NREG-1). X0 reads 0. X0 is never busy.
- Out-of-range address (≥ NREG):
  - Read returns 0 and busy 0.
  - Write and reservation are ignored.
- Write: if wr_en, wr_addr ≠ 0 and in range, X[wr_addr] ← wr_data at the edge.
- Read, per port p:
  - If BYPASS=1, wr_en, wr_addr == rd_addr[p] ≠ 0 and in range: rd_data[p] = wr_data.
  - Otherwise rd_data[p] = X[rd_addr[p]].
- Busy bit per register. Priority at the edge is rst > flush > rsv > wr:
  - rst: all busy bits cleared.
  - flush: all busy bits cleared; rsv_en and the wr_en busy-clear are ignored that cycle; the data write still happens.
  - rsv_en to a valid address: sets busy[rsv_addr].
  - wr_en to a valid address: clears busy[wr_addr], unless rsv_en targets the same address that cycle. In that case busy stays 1 (new producer wins) and the data is still written.
- rd_busy[p] = busy[rd_addr[p]], with one exception: if BYPASS=1 and the port is being bypassed this cycle, rd_busy[p] = 0 (the value is available now).
- busy_cnt is updated every cycle to the population count of the next-state busy vector.
- Reservation of an already-busy register: bit stays 1, busy_cnt unchanged.
- Write to a non-busy register: data written, no busy change.

## Timing
- Reset state (one rst cycle): all X = 0, all busy = 0, busy_cnt = 0. Combinationally, rd_data = 0 and rd_busy = 0 for every port.
- rst asserted mid-operation discards pending reservations; a write in the same cycle is dropped.
- Write latency:
  - Array: new value is visible at rd_data from the cycle after the edge.
  - Bypass: visible in the same cycle.
- Reservation latency: rd_busy rises the cycle after rsv_en. A same-cycle read of that register still shows not-busy (decode handles same-bundle hazards).
- busy_cnt lags the busy vector by zero cycles: it is registered alongside it.
- No handshake. Every input is sampled every cycle and there is no backpressure.

## Structure
- Shared package rv_pkg holds:
  - constants XLEN_DEF = 64, NREG_DEF = 32, AW = 5;
  - typedef regaddr_t (logic [4:0]);
  - function is_valid_reg(addr, nreg).
- Sub-module rv_scoreboard:
  - contains the busy vector, rsv/wr/flush priority and the registered popcount for busy_cnt;
  - inputs are clk, rst, rsv/wr/flush;
  - outputs are the busy vector and busy_cnt.
- Top level contains the data array, per-port read muxes with bypass, and rd_busy derivation. Read ports are built with a generate loop over NRP.

## Test plan
- Reset, then write X5 = 0xDEAD_BEEF_0123_4567 → next cycle rd_addr[0] = 5 returns that value. A write to X0 = 0xFFFF… → X0 reads 0.
- BYPASS=1: wr_en to X7 = 0x55 while rd_addr[1] = 7 → rd_data[1] = 0x55 and rd_busy[1] = 0 in the same cycle. With BYPASS=0, the same stimulus returns the old value 0.
- rsv X3, X4 on consecutive cycles → busy_cnt goes 1 then 2, and rd_busy for 3 is high. Write X3 → busy_cnt = 1. Same-cycle rsv X4 + wr X4 → X4 stays busy, busy_cnt = 1, data updated.
- Reserve X1..X6, then flush together with rsv X9 → busy_cnt = 0 the next cycle and X9 is not busy. rst while X2 is reserved and wr_en is pending → all registers read 0 and busy_cnt = 0.
- NREG=16, XLEN=32, NRP=3: write X20 and rsv X20 → ignored; rd_addr = 20 returns 0 and not-busy. All 3 ports reading X15 return the same value.
